// File: rtl/code_enroll.sv
// code_enroll: enrolment writer for the 4-digit password checker.
// Turns one-hot switch presses into digits, runs a "new code / confirm code"
// two-pass FSM, and commits a matching code to the register the checker reads.
// Drives five active-low seven-segment digits (gfedcba).
// Optional feature: define CODE_ENROLL_TIMEOUT_EN to abort an entry that sees
// no event for TIMEOUT_TICKS tick periods.
module code_enroll #(
  parameter logic [15:0] DEFAULT_CODE  = 16'h2016,
  parameter int          TIMEOUT_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [0:9]  switches,
  input  logic        set_btn,
  output logic [15:0] code,
  output logic        code_update,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4
);

  // FSM encoding; NEW0..NEW3 and CONF0..CONF3 are consecutive so "+1" advances
  // and NEW3+1 lands on CONF0.
  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] NEW0  = 4'd1;
  localparam logic [3:0] NEW3  = 4'd4;
  localparam logic [3:0] CONF0 = 4'd5;
  localparam logic [3:0] CONF3 = 4'd8;
  localparam logic [3:0] SAVED = 4'd9;
  localparam logic [3:0] ERROR = 4'd10;

  // Segment patterns, gfedcba, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Edge-detect history
  logic [0:9] sw_prev;
  logic       set_prev;

  // FSM state and staging; stage[0] is digit 1 and lands in code[15:12]
  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [0:3][3:0]  stage;
  logic [0:3][3:0]  stage_next;
  logic             mismatch;
  logic             mismatch_next;
  logic             commit;

  // Display registers, index i drives hex<i>
  logic [6:0] hex_q    [0:4];
  logic [6:0] hex_next [0:4];

  // Event decode
  logic [0:9] press;
  logic [9:0] press_flat;
  logic       set_edge;
  logic       any_press;
  logic       is_invalid;
  logic       is_digit;
  logic [3:0] digit_val;
  logic       any_event;

  // State classification
  logic       in_new;
  logic       in_conf;
  logic [1:0] new_idx;
  logic [1:0] conf_idx;
  logic       conf_mm;

  // Rising edges relative to the history captured at the previous tick
  always_comb begin
    press      = switches & ~sw_prev;
    press_flat = press;
    set_edge   = set_btn & ~set_prev;
    any_press  = |press_flat;
    // Clearing the lowest set bit leaves something only when two or more are set.
    is_invalid = |(press_flat & (press_flat - 10'd1));
    is_digit   = any_press & ~is_invalid;
    any_event  = set_edge | any_press;
  end

  // One-hot to decimal encoder; only meaningful when is_digit is set
  logic [3:0] enc_terms [0:9];
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_enc
      assign enc_terms[gi] = press[gi] ? 4'(gi) : 4'd0;
    end
  endgenerate

  // OR-reduce the encoder terms into the digit value
  always_comb begin
    digit_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      digit_val = digit_val | enc_terms[i];
    end
  end

  // Decode which entry pass the current state belongs to
  always_comb begin
    in_new   = (state >= NEW0) && (state <= NEW3);
    in_conf  = (state >= CONF0) && (state <= CONF3);
    new_idx  = 2'(state - NEW0);
    conf_idx = 2'(state - CONF0);
    conf_mm  = mismatch | (digit_val != stage[conf_idx]);
  end

`ifdef CODE_ENROLL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_cnt_next;
`endif

  // Next-state, staging and commit decision for one tick
  always_comb begin
    state_next    = state;
    stage_next    = stage;
    mismatch_next = mismatch;
    commit        = 1'b0;
`ifdef CODE_ENROLL_TIMEOUT_EN
    idle_cnt_next = '0;
`endif
    if (state == IDLE) begin
      if (set_edge) begin
        state_next    = NEW0;
        stage_next    = '0;
        mismatch_next = 1'b0;
      end
    end else if (in_new || in_conf) begin
      // set_edge outranks a digit arriving on the same tick
      if (set_edge) begin
        state_next    = NEW0;
        stage_next    = '0;
        mismatch_next = 1'b0;
      end else if (is_invalid) begin
        state_next = ERROR;
      end else if (is_digit) begin
        if (in_new) begin
          stage_next[new_idx] = digit_val;
          state_next          = state + 4'd1;
        end else if (state == CONF3) begin
          if (conf_mm) begin
            state_next = ERROR;
          end else begin
            state_next = SAVED;
            commit     = 1'b1;
          end
        end else begin
          mismatch_next = conf_mm;
          state_next    = state + 4'd1;
        end
      end
`ifdef CODE_ENROLL_TIMEOUT_EN
      else begin
        // Quiet tick inside an entry pass: count it, abort when the limit is hit
        if (idle_cnt == TW'(TIMEOUT_TICKS - 1)) begin
          state_next    = ERROR;
          stage_next    = '0;
          mismatch_next = 1'b0;
        end else begin
          idle_cnt_next = idle_cnt + 1'b1;
        end
      end
`endif
    end else if ((state == SAVED) || (state == ERROR)) begin
      // The exit event is swallowed; it never starts a new entry
      if (any_event) begin
        state_next = IDLE;
      end
    end else begin
      state_next = IDLE;
    end
  end

  // Dashes shown for the digits entered in the current pass, hex3 first
  logic [2:0] dash_cnt;
  logic [3:0] dash_on;

  always_comb begin
    dash_cnt = 3'd0;
    if ((state_next >= NEW0) && (state_next <= NEW3)) begin
      dash_cnt = 3'(state_next - NEW0);
    end else if ((state_next >= CONF0) && (state_next <= CONF3)) begin
      dash_cnt = 3'(state_next - CONF0);
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_dash
      // dash_on[gi] drives hex(3-gi)
      assign dash_on[gi] = (dash_cnt > 3'(gi));
    end
  endgenerate

  // Segment pattern for the state being entered
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      hex_next[i] = SEG_BLANK;
    end
    if ((state_next >= NEW0) && (state_next <= CONF3)) begin
      hex_next[4] = (state_next <= NEW3) ? SEG_N : SEG_C;
      for (int i = 0; i < 4; i++) begin
        if (dash_on[i]) begin
          hex_next[3 - i] = SEG_DASH;
        end
      end
    end else if (state_next == SAVED) begin
      hex_next[3] = SEG_D;
      hex_next[2] = SEG_O;
      hex_next[1] = SEG_N;
      hex_next[0] = SEG_E;
    end else if (state_next == ERROR) begin
      hex_next[4] = SEG_E;
      hex_next[3] = SEG_R;
      hex_next[2] = SEG_R;
    end
  end

  // Tick-gated state, history, staging, code and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_prev  <= 10'h3FF;
      set_prev <= 1'b1;
      state    <= IDLE;
      stage    <= '0;
      mismatch <= 1'b0;
      code     <= DEFAULT_CODE;
      for (int i = 0; i < 5; i++) begin
        hex_q[i] <= SEG_BLANK;
      end
    end else if (tick) begin
      sw_prev  <= switches;
      set_prev <= set_btn;
      state    <= state_next;
      stage    <= stage_next;
      mismatch <= mismatch_next;
      if (commit) begin
        code <= stage_next;
      end
      for (int i = 0; i < 5; i++) begin
        hex_q[i] <= hex_next[i];
      end
    end
  end

  // Commit strobe lasts exactly one clk regardless of tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_update <= 1'b0;
    end else begin
      code_update <= tick & commit;
    end
  end

`ifdef CODE_ENROLL_TIMEOUT_EN
  // Inactivity counter; held at zero outside the entry passes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (tick) begin
      idle_cnt <= idle_cnt_next;
    end
  end
`endif

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];

endmodule
